phy_tx_serializer: RTL and testbench

PHY_TX_SERIALIZER -- requirements
Module: phy_tx_serializer

---
 rtl/phy_pkg.sv | 27 ++
 rtl/lane_serializer.sv | 23 ++
 rtl/phy_tx_serializer.sv | 68 ++++++
 tb/tb_phy_tx_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: slot geometry, COM symbol, lane striping and FSM encoding.
// Used by both the transmit serializer and the receive deserializer.
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;
  localparam int         SLOT_BITS  = 16;
  localparam int         NUM_LANES  = 2;
  localparam int         CNT_W      = 4;

  localparam logic [SLOT_BITS-1:0] COM_LANE = {COM_SYMBOL, COM_SYMBOL};
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SLOT_BITS - 1);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_e;

  // Lane 0 carries B3 then B1, lane 1 carries B2 then B0.
  function automatic logic [SLOT_BITS-1:0] lane_bytes(input logic [31:0] word, input int lane);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = word >> (24 - 8 * lane);
    lo = word >> (8 - 8 * lane);
    return {hi[7:0], lo[7:0]};
  endfunction

endpackage

// File: rtl/lane_serializer.sv
// One serial lane: parallel load of a slot word, then MSB-first shift-out.
// Output is bit W-1 of the register, so a load shows its MSB the very next cycle.
module lane_serializer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         ser_out
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sr <= '0;
    else if (load) sr <= load_val;
    else           sr <= {sr[W-2:0], 1'b0};
  end

  assign ser_out = sr[W-1];

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane slot serializer: COM-only sync preamble after reset, then one
// 32-bit user word or one COM idle fill per 16-cycle slot.
module phy_tx_serializer
  import phy_pkg::*;
#(
  parameter int SYNC_SLOTS = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out_0,
  output logic        data_out_1,
  output logic        data_slot_out
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_SLOTS - 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       sync_cnt;
  phy_state_e       state;
  logic             slot_load;
  logic             accept;

  logic [NUM_LANES-1:0][SLOT_BITS-1:0] load_val;
  logic [NUM_LANES-1:0]                ser;

  assign slot_load = (cnt == CNT_LAST);
  // Depends only on registers so the sender can never form a combinational loop.
  assign ready_out = (state == ST_ACTIVE) && slot_load;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      cnt           <= CNT_LAST;
      sync_cnt      <= '0;
      state         <= ST_SYNC;
      data_slot_out <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_load) begin
        data_slot_out <= accept;
        if (state == ST_SYNC) begin
          // The slot loaded at this edge is the last preamble slot.
          if (sync_cnt == SYNC_LAST) state    <= ST_ACTIVE;
          else                       sync_cnt <= sync_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign load_val[l] = accept ? lane_bytes(data_in, l) : COM_LANE;

    lane_serializer #(.W(SLOT_BITS)) u_lane (
      .clk      (clk_32f),
      .rst      (reset),
      .load     (slot_load),
      .load_val (load_val[l]),
      .ser_out  (ser[l])
    );
  end

  assign data_out_0 = ser[0];
  assign data_out_1 = ser[1];

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer: sync preamble, single/back-to-back
// words, valid during sync, mid-slot reset and a random-word loopback capture.
module tb_phy_tx_serializer;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out, data_out_0, data_out_1, data_slot_out;

  int errors = 0;
  int checks = 0;

  phy_tx_serializer #(.SYNC_SLOTS(4)) dut (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_out_0    (data_out_0),
    .data_out_1    (data_out_1),
    .data_slot_out (data_slot_out)
  );

  always #5 clk_32f = ~clk_32f;

  // Stimulus helpers only; all comparisons live in the test tasks.
  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (ready_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_32f);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_32f);
    checks++;
    if ({data_out_0, data_out_1, data_slot_out, ready_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {data_out_0, data_out_1, data_slot_out, ready_out});
    end
  endtask

  task automatic test_sync_idle();
    logic [15:0] com = 16'hBCBC;
    logic        exp_bit, exp_rdy;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_32f);
      exp_bit = com[15 - (k % 16)];
      exp_rdy = (k >= 63) && (k % 16 == 15);
      checks++;
      if (data_out_0 !== exp_bit || data_out_1 !== exp_bit) begin
        errors++;
        $display("FAIL sync_com_bit k=%0d: got %b%b expected %b%b", k, data_out_0, data_out_1, exp_bit, exp_bit);
      end
      checks++;
      if (ready_out !== exp_rdy) begin
        errors++;
        $display("FAIL sync_ready k=%0d: got %b expected %b", k, ready_out, exp_rdy);
      end
      checks++;
      if (data_slot_out !== 1'b0) begin
        errors++;
        $display("FAIL sync_slot k=%0d: got %b expected 0", k, data_slot_out);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [31:0] word,
                             input logic [15:0] exp0, input logic [15:0] exp1);
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_ready_timeout: got ready=%b expected 1", name, ready_out);
    end
    data_in  = word;
    valid_in = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_32f);
      if (j == 0) valid_in = 1'b0;
      checks++;
      if (data_out_0 !== exp0[15-j] || data_out_1 !== exp1[15-j]) begin
        errors++;
        $display("FAIL %s_bit j=%0d: got %b%b expected %b%b", name, j, data_out_0, data_out_1, exp0[15-j], exp1[15-j]);
      end
      checks++;
      if (data_slot_out !== 1'b1 || ready_out !== (j == 15)) begin
        errors++;
        $display("FAIL %s_slot_ready j=%0d: got slot=%b ready=%b expected slot=1 ready=%b",
                 name, j, data_slot_out, ready_out, (j == 15));
      end
    end
    @(negedge clk_32f);
    checks++;
    if (data_slot_out !== 1'b0 || data_out_0 !== 1'b1 || data_out_1 !== 1'b1) begin
      errors++;
      $display("FAIL %s_com_resume: got slot=%b bits=%b%b expected slot=0 bits=11",
               name, data_slot_out, data_out_0, data_out_1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2] = '{32'h01234567, 32'h89ABCDEF};
    logic [15:0] e0 [2] = '{16'h0145, 16'h89CD};
    logic [15:0] e1 [2] = '{16'h2367, 16'hABEF};
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_ready_timeout: got ready=%b expected 1", ready_out);
    end
    data_in  = w[0];
    valid_in = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk_32f);
        if (s == 1 && j == 0) valid_in = 1'b0;
        checks++;
        if (data_out_0 !== e0[s][15-j] || data_out_1 !== e1[s][15-j] || data_slot_out !== 1'b1) begin
          errors++;
          $display("FAIL b2b_word%0d j=%0d: got bits=%b%b slot=%b expected bits=%b%b slot=1",
                   s, j, data_out_0, data_out_1, data_slot_out, e0[s][15-j], e1[s][15-j]);
        end
        checks++;
        if (ready_out !== (j == 15)) begin
          errors++;
          $display("FAIL b2b_ready s=%0d j=%0d: got %b expected %b", s, j, ready_out, (j == 15));
        end
        if (j == 15 && s == 0) data_in = w[1];
      end
    end
    @(negedge clk_32f);
    checks++;
    if (data_slot_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: got slot=%b expected 0", data_slot_out);
    end
  endtask

  task automatic test_sync_valid();
    logic [15:0] com = 16'hBCBC;
    logic [15:0] e0 = 16'hCAF0;
    logic [15:0] e1 = 16'hFE0D;
    reset    = 1'b1;
    data_in  = 32'hCAFEF00D;
    valid_in = 1'b1;
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_32f);
      checks++;
      if (data_slot_out !== 1'b0 || ready_out !== (k == 63) || data_out_0 !== com[15-(k%16)]) begin
        errors++;
        $display("FAIL syncvalid_held k=%0d: got slot=%b ready=%b bit=%b expected slot=0 ready=%b bit=%b",
                 k, data_slot_out, ready_out, data_out_0, (k == 63), com[15-(k%16)]);
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_32f);
      if (j == 0) valid_in = 1'b0;
      checks++;
      if (data_out_0 !== e0[15-j] || data_out_1 !== e1[15-j] || data_slot_out !== 1'b1) begin
        errors++;
        $display("FAIL syncvalid_word j=%0d: got bits=%b%b slot=%b expected bits=%b%b slot=1",
                 j, data_out_0, data_out_1, data_slot_out, e0[15-j], e1[15-j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] com = 16'hBCBC;
    logic [15:0] e0 = 16'h1256;
    logic [15:0] e1 = 16'h3478;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_ready_timeout: got ready=%b expected 1", ready_out);
    end
    data_in  = 32'hFFFFFFFF;
    valid_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_32f);
      if (j == 0) valid_in = 1'b0;
    end
    checks++;
    if ({data_out_0, data_out_1, data_slot_out} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_before: got %b expected 111", {data_out_0, data_out_1, data_slot_out});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({data_out_0, data_out_1, data_slot_out, ready_out} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async_clear: got %b expected 0000",
               {data_out_0, data_out_1, data_slot_out, ready_out});
    end
    @(negedge clk_32f);
    reset    = 1'b0;
    data_in  = 32'h12345678;
    valid_in = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_32f);
      checks++;
      if (data_slot_out !== 1'b0 || ready_out !== (k == 63) || data_out_1 !== com[15-(k%16)]) begin
        errors++;
        $display("FAIL midrst_resync k=%0d: got slot=%b ready=%b bit=%b expected slot=0 ready=%b bit=%b",
                 k, data_slot_out, ready_out, data_out_1, (k == 63), com[15-(k%16)]);
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_32f);
      if (j == 0) valid_in = 1'b0;
      checks++;
      if (data_out_0 !== e0[15-j] || data_out_1 !== e1[15-j] || data_slot_out !== 1'b1) begin
        errors++;
        $display("FAIL midrst_word j=%0d: got bits=%b%b slot=%b expected bits=%b%b slot=1",
                 j, data_out_0, data_out_1, data_slot_out, e0[15-j], e1[15-j]);
      end
    end
  endtask

  task automatic test_loopback();
    logic [31:0] sent [6];
    logic [31:0] rcvd [$];
    logic [15:0] l0, l1;
    int nb = 0;
    int ns = 0;
    bit ok;
    for (int i = 0; i < 6; i++) sent[i] = $urandom;
    sent[2] = 32'hBCBCBCBC;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_ready_timeout: got ready=%b expected 1", ready_out);
    end
    data_in  = sent[0];
    valid_in = 1'b1;
    ns = 1;
    for (int t = 0; t < 140 && rcvd.size() < 6; t++) begin
      @(negedge clk_32f);
      if (data_slot_out === 1'b1) begin
        l0 = {l0[14:0], data_out_0};
        l1 = {l1[14:0], data_out_1};
        nb++;
        if (nb == 16) begin
          rcvd.push_back({l0[15:8], l1[15:8], l0[7:0], l1[7:0]});
          nb = 0;
        end
      end
      if (ready_out === 1'b1) begin
        if (ns < 6) data_in = sent[ns];
        else        valid_in = 1'b0;
        ns++;
      end
    end
    valid_in = 1'b0;
    checks++;
    if (rcvd.size() != 6) begin
      errors++;
      $display("FAIL loop_count: got %0d words expected 6", rcvd.size());
    end
    for (int i = 0; i < 6 && i < rcvd.size(); i++) begin
      checks++;
      if (rcvd[i] !== sent[i]) begin
        errors++;
        $display("FAIL loop_word%0d: got %h expected %h", i, rcvd[i], sent[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_idle();
    test_single("deadbeef", 32'hDEADBEEF, 16'hDEBE, 16'hADEF);
    test_single("comdata", 32'hBC12BC34, 16'hBCBC, 16'h1234);
    test_back_to_back();
    test_sync_valid();
    test_mid_reset();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
